// File: rtl/controlador_teclas_pkg.sv
// Shared types and helpers for the switch-bank key controller.
// Helpers take a MAX_SW-wide vector; callers zero-extend narrower banks.
package controlador_teclas_pkg;

    localparam int MAX_SW = 64;

    typedef enum logic [1:0] {
        SOLTO,
        PRESSIONADO,
        INVALIDO
    } estado_t;

    function automatic logic is_onehot(input logic [MAX_SW-1:0] v);
        return (v != '0) && ((v & (v - MAX_SW'(1))) == '0);
    endfunction

    function automatic int encode_onehot(input logic [MAX_SW-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_SW; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_teclas.sv
// Small show-ahead FIFO: dout is a register that always holds the current head,
// so a consumer sees the code in the same cycle valid is high.
module fifo_teclas #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop & valid;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);

    assign dout  = dout_reg;
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            // Keep dout pointing at the next head; hold it when the queue drains.
            if (do_pop) begin
                if (count_reg > CNT_W'(1)) begin
                    dout_reg <= mem[rd_ptr_reg + PTR_W'(1)];
                end else if (do_push) begin
                    dout_reg <= din;
                end
            end else if (!valid && do_push) begin
                dout_reg <= din;
            end
        end
    end

endmodule

// File: rtl/controlador_teclas_fifo.sv
// Switch bank to key-code queue: synchronise, debounce, accept one-hot presses
// once per press, and buffer the codes for a slow consumer.
module controlador_teclas_fifo
    import controlador_teclas_pkg::*;
#(
    parameter int N_SW            = 16,
    parameter int W_TECLA         = $clog2(N_SW),
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_SW-1:0]               SW,
    input  logic                          ack,
    output logic [W_TECLA-1:0]            tecla,
    output logic                          valid,
    output logic                          ready,
    output logic                          erro,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [N_SW-1:0]    sync_q1;
    logic [N_SW-1:0]    sync_q2;
    logic [N_SW-1:0]    candidate_reg;
    logic [N_SW-1:0]    stable_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [MAX_SW-1:0]  stable_ext;
    logic               stable_onehot;
    logic [W_TECLA-1:0] stable_code;
    logic [N_SW-1:0]    pressed_pattern;

    estado_t            state_reg, state_next;
    logic               push_reg, push_next;
    logic               erro_reg, erro_next;
    logic [W_TECLA-1:0] code_reg, code_next;
    logic               ready_reg;
    logic               overflow_reg;
    logic               fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1       <= '0;
            sync_q2       <= '0;
            candidate_reg <= '0;
            stable_reg    <= '0;
            cnt_reg       <= '0;
        end else begin
            sync_q1 <= SW;
            sync_q2 <= sync_q1;
            if (sync_q2 != candidate_reg) begin
                candidate_reg <= sync_q2;
                cnt_reg       <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_reg <= candidate_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stable_ext    = MAX_SW'(stable_reg);
    assign stable_onehot = is_onehot(stable_ext);
    assign stable_code   = W_TECLA'(encode_onehot(stable_ext));

    // One-hot image of the key currently held, used to spot a change of key.
    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_pattern
            assign pressed_pattern[gi] = (code_reg == W_TECLA'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        push_next  = 1'b0;
        erro_next  = 1'b0;
        code_next  = code_reg;
        case (state_reg)
            SOLTO: begin
                if (stable_reg != '0) begin
                    if (stable_onehot) begin
                        state_next = PRESSIONADO;
                        push_next  = 1'b1;
                        code_next  = stable_code;
                    end else begin
                        state_next = INVALIDO;
                        erro_next  = 1'b1;
                    end
                end
            end
            PRESSIONADO: begin
                if (stable_reg == '0) begin
                    state_next = SOLTO;
                end else if (stable_reg != pressed_pattern) begin
                    state_next = INVALIDO;
                    erro_next  = 1'b1;
                end
            end
            INVALIDO: begin
                if (stable_reg == '0) begin
                    state_next = SOLTO;
                end
            end
            default: state_next = SOLTO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= SOLTO;
            push_reg     <= 1'b0;
            erro_reg     <= 1'b0;
            code_reg     <= '0;
            ready_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            push_reg  <= push_next;
            erro_reg  <= erro_next;
            code_reg  <= code_next;
            ready_reg <= stable_onehot;
            if (push_reg && fifo_full && !(ack && valid)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    fifo_teclas #(
        .WIDTH (W_TECLA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_reg),
        .din   (code_reg),
        .pop   (ack),
        .dout  (tecla),
        .valid (valid),
        .full  (fifo_full),
        .count (count)
    );

    assign ready    = ready_reg;
    assign erro     = erro_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_controlador_teclas_fifo.sv
// Bench for controlador_teclas_fifo: directed scenarios plus random presses,
// with expected key codes queued at stimulus time and checked by a pop monitor.
module tb_controlador_teclas_fifo;

    localparam int N_SW  = 16;
    localparam int W     = 4;
    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            ack;
    logic [N_SW-1:0] SW;
    logic [W-1:0]    tecla;
    logic            valid;
    logic            ready;
    logic            erro;
    logic            overflow;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int erro_exp = 0;
    int erro_seen = 0;
    int mon_exp;
    bit rand_ack = 1'b0;
    int kind, a, b, nb, guard;

    always #5 clk = ~clk;

    controlador_teclas_fifo #(
        .N_SW            (N_SW),
        .W_TECLA         (W),
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .SW       (SW),
        .ack      (ack),
        .tecla    (tecla),
        .valid    (valid),
        .ready    (ready),
        .erro     (erro),
        .overflow (overflow),
        .count    (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        ack = 1'b0;
    endtask

    task automatic ack_one();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic press_release(input int k, input bit expect_push);
        SW = N_SW'(1) << k;
        if (expect_push) exp_q.push_back(k);
        hold(15);
        SW = '0;
        hold(15);
    endtask

    // Monitor: every accepted pop must deliver the oldest expected code.
    always @(negedge clk) begin
        if (!reset) begin
            if (erro) erro_seen++;
            if (valid && ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got tecla=%0d, expected no entry", tecla);
                end else begin
                    mon_exp = exp_q.pop_front();
                    $display("pop tecla=%0d expected=%0d", tecla, mon_exp);
                    check("pop_order", 32'(tecla), mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        SW    = '0;
        ack   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_zero", {valid, ready, erro, count}, 0);
        end
        check("reset_tecla", 32'(tecla), 0);

        // Single press: latency and no auto-repeat
        SW = 16'h0008;
        exp_q.push_back(3);
        repeat (8) tick();
        check("latency_before", 32'(valid), 0);
        tick();
        check("latency_valid", 32'(valid), 1);
        check("latency_tecla", 32'(tecla), 3);
        check("ready_onehot", 32'(ready), 1);
        repeat (50) tick();
        check("no_repeat_count", 32'(count), 1);
        SW = '0;
        repeat (15) tick();
        check("ready_released", 32'(ready), 0);
        ack_one();
        check("drain_single", 32'(valid), 0);

        // Bouncing contact settles into one press
        for (int i = 0; i < 6; i++) begin
            SW = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            repeat (2) tick();
        end
        SW = 16'h0020;
        exp_q.push_back(5);
        repeat (8) tick();
        check("bounce_before", 32'(valid), 0);
        tick();
        check("bounce_valid", 32'(valid), 1);
        check("bounce_tecla", 32'(tecla), 5);
        repeat (20) tick();
        check("bounce_single_push", 32'(count), 1);
        SW = '0;
        repeat (15) tick();
        ack_one();

        // Two keys at once: error pulse, nothing queued
        SW = 16'h0101;
        erro_exp++;
        repeat (15) tick();
        check("multi_ready", 32'(ready), 0);
        check("multi_no_push", 32'(valid), 0);
        check("multi_erro_pulse", erro_seen, erro_exp);
        SW = '0;
        repeat (15) tick();
        SW = 16'h8000;
        exp_q.push_back(15);
        repeat (12) tick();
        check("after_invalid_valid", 32'(valid), 1);
        check("after_invalid_tecla", 32'(tecla), 15);
        SW = '0;
        repeat (15) tick();
        ack_one();

        // Fill past capacity with no consumer
        for (int k = 0; k < 5; k++) press_release(k, k < DEPTH);
        check("ovf_count", 32'(count), DEPTH);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_head", 32'(tecla), 0);
        for (int k = 0; k < 4; k++) begin
            ack_one();
            tick();
        end
        check("ovf_drained", 32'(valid), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Reset in the middle of queued codes and a press
        press_release(11, 1'b1);
        press_release(12, 1'b1);
        check("pre_reset_count", 32'(count), 2);
        SW = N_SW'(1) << 13;
        repeat (5) tick();
        reset = 1'b1;
        SW = '0;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_tecla", 32'(tecla), 0);
        repeat (20) tick();
        check("rst_press_dropped", 32'(valid), 0);

        // Full FIFO with push and pop in the same cycle
        for (int k = 6; k < 10; k++) press_release(k, 1'b1);
        check("full_count", 32'(count), DEPTH);
        SW = N_SW'(1) << 10;
        exp_q.push_back(10);
        repeat (8) tick();
        check("full_before_push", 32'(count), DEPTH);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("full_pushpop_count", 32'(count), DEPTH);
        check("full_no_overflow", 32'(overflow), 0);
        SW = '0;
        repeat (15) tick();
        for (int k = 0; k < 4; k++) begin
            ack_one();
            tick();
        end
        check("full_drained", 32'(valid), 0);
        check("full_overflow_final", 32'(overflow), 0);

        // Random presses against a consumer acking at random
        rand_ack = 1'b1;
        for (int n = 0; n < 40; n++) begin
            guard = 0;
            while (exp_q.size() >= DEPTH && guard < 200) begin
                ack = 1'b1;
                tick();
                guard++;
            end
            ack = 1'b0;
            if (exp_q.size() >= DEPTH) begin
                checks++;
                errors++;
                $display("FAIL room_timeout: got %0d queued, expected below %0d", exp_q.size(), DEPTH);
            end
            kind = $urandom_range(0, 9);
            a = $urandom_range(0, N_SW - 1);
            b = (a + $urandom_range(1, N_SW - 1)) % N_SW;
            if (kind < 5) begin
                SW = N_SW'(1) << a;
                exp_q.push_back(a);
                hold($urandom_range(12, 30));
            end else if (kind < 7) begin
                nb = $urandom_range(2, 6);
                for (int j = 0; j < nb; j++) begin
                    SW = (j % 2 == 0) ? (N_SW'(1) << a) : '0;
                    hold($urandom_range(1, 2));
                end
                SW = N_SW'(1) << a;
                exp_q.push_back(a);
                hold($urandom_range(12, 30));
            end else if (kind < 9) begin
                SW = (N_SW'(1) << a) | (N_SW'(1) << b);
                erro_exp++;
                hold($urandom_range(12, 30));
            end else begin
                SW = N_SW'(1) << a;
                exp_q.push_back(a);
                hold($urandom_range(15, 25));
                SW = N_SW'(1) << b;
                erro_exp++;
                hold($urandom_range(15, 25));
            end
            SW = '0;
            hold($urandom_range(12, 20));
        end
        rand_ack = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            ack = 1'b1;
            tick();
            guard++;
        end
        ack = 1'b0;
        tick();
        check("rand_drain_empty", exp_q.size(), 0);
        check("rand_valid_final", 32'(valid), 0);
        check("rand_no_overflow", 32'(overflow), 0);
        check("rand_erro_pulses", erro_seen, erro_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
